axi4_subordinate_mem: RTL and testbench

Single-beat AXI4 subordinate that terminates the manager's five channels (AW, W, B, AR, R) on a local word-addressed memory array. It is the responder end of the manager's TX/RX channel pairs. It accepts AW and W in any order, commits the write, and returns BRESP. It accepts AR independently and returns RDATA/RRESP. The read and write paths run concurrently and are each limited to one transaction in flight. The block is used as the DUT-side memory for manager benches and as a simple on-chip target.

---
 rtl/axi4_subordinate_mem_if.sv | 39 +++
 rtl/axi4_subordinate_mem.sv | 175 +++++++++++++++++
 tb/tb_axi4_subordinate_mem.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_subordinate_mem_if.sv
// AXI4 single-beat channel bundle (AW, W, B, AR, R) between a manager and the memory subordinate.
// Every channel moves on the edge where VALID and READY are both high; VALID never drops before then.
interface axi4_subordinate_mem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] AWADDR;
    logic              AWVALID;
    logic              AWREADY;
    logic [DATA_W-1:0] WDATA;
    logic              WVALID;
    logic              WREADY;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY;
    logic [ADDR_W-1:0] ARADDR;
    logic              ARVALID;
    logic              ARREADY;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RVALID;
    logic              RREADY;

    modport master (
        output AWADDR, AWVALID, input AWREADY,
        output WDATA, WVALID, input WREADY,
        input BRESP, BVALID, output BREADY,
        output ARADDR, ARVALID, input ARREADY,
        input RDATA, RRESP, RVALID, output RREADY
    );

    modport slave (
        input AWADDR, AWVALID, output AWREADY,
        input WDATA, WVALID, output WREADY,
        output BRESP, BVALID, input BREADY,
        input ARADDR, ARVALID, output ARREADY,
        output RDATA, RRESP, RVALID, input RREADY
    );
endinterface

// File: rtl/axi4_subordinate_mem.sv
// Single-beat AXI4 subordinate backed by a word-addressed memory array.
// Independent write (AW+W -> commit -> B) and read (AR -> R) FSMs, one transaction each in flight.
module axi4_subordinate_mem #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_DEPTH = 1024
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    axi4_subordinate_mem_if.slave bus,
    output logic [1:0]           w_state_dbg,
    output logic                 r_state_dbg
);
    localparam int BYTE_SH = $clog2(DATA_W / 8);
    localparam int IDX_W   = $clog2(MEM_DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_COMMIT = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_RESP = 1'b1} r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [ADDR_W-1:0] aw_addr;
    logic [DATA_W-1:0] w_data;
    logic              aw_got, w_got;
    logic              aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic              mem_we;
    logic [ADDR_W-1:0] w_idx, r_idx;
    logic              w_in_range, r_in_range;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    // An index is in range when every bit above the array's index width is zero.
    assign w_idx      = aw_addr >> BYTE_SH;
    assign r_idx      = bus.ARADDR >> BYTE_SH;
    assign w_in_range = (w_idx >> IDX_W) == '0;
    assign r_in_range = (r_idx >> IDX_W) == '0;

    assign w_state_dbg = w_state;
    assign r_state_dbg = r_state;

    // ---------------- write FSM ----------------
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) w_state <= W_IDLE;
        else          w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:   if ((aw_got || aw_hs) && (w_got || w_hs)) w_next = W_COMMIT;
            W_COMMIT: w_next = W_RESP;
            W_RESP:   if (b_hs) w_next = W_IDLE;
            default:  w_next = W_IDLE;
        endcase
    end

    always_comb begin
        aw_hs  = 1'b0;
        w_hs   = 1'b0;
        b_hs   = 1'b0;
        mem_we = 1'b0;
        case (w_state)
            W_IDLE: begin
                aw_hs = bus.AWVALID && bus.AWREADY;
                w_hs  = bus.WVALID && bus.WREADY;
            end
            W_COMMIT: mem_we = w_in_range;
            W_RESP:   b_hs   = bus.BVALID && bus.BREADY;
            default:  ;
        endcase
    end

    // Readies are registered: they rise on the first edge out of reset and after each B handshake.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            bus.AWREADY <= 1'b0;
            bus.WREADY  <= 1'b0;
            bus.BVALID  <= 1'b0;
            bus.BRESP   <= RESP_OKAY;
            aw_got      <= 1'b0;
            w_got       <= 1'b0;
            aw_addr     <= '0;
            w_data      <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_addr <= bus.AWADDR;
                        aw_got  <= 1'b1;
                    end
                    if (w_hs) begin
                        w_data <= bus.WDATA;
                        w_got  <= 1'b1;
                    end
                    bus.AWREADY <= !(aw_got || aw_hs);
                    bus.WREADY  <= !(w_got || w_hs);
                end
                W_COMMIT: begin
                    bus.BVALID <= 1'b1;
                    bus.BRESP  <= w_in_range ? RESP_OKAY : RESP_SLVERR;
                end
                W_RESP: begin
                    if (b_hs) begin
                        bus.BVALID  <= 1'b0;
                        aw_got      <= 1'b0;
                        w_got       <= 1'b0;
                        bus.AWREADY <= 1'b1;
                        bus.WREADY  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (mem_we) mem[w_idx[IDX_W-1:0]] <= w_data;
    end

    // ---------------- read FSM ----------------
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) r_state <= R_IDLE;
        else          r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_RESP;
            R_RESP:  if (r_hs) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        ar_hs = 1'b0;
        r_hs  = 1'b0;
        case (r_state)
            R_IDLE:  ar_hs = bus.ARVALID && bus.ARREADY;
            R_RESP:  r_hs  = bus.RVALID && bus.RREADY;
            default: ;
        endcase
    end

    // The array read sees pre-edge contents, so a same-edge commit returns the old word.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            bus.ARREADY <= 1'b0;
            bus.RVALID  <= 1'b0;
            bus.RDATA   <= '0;
            bus.RRESP   <= RESP_OKAY;
        end else begin
            case (r_state)
                R_IDLE: begin
                    bus.ARREADY <= !ar_hs;
                    if (ar_hs) begin
                        bus.RVALID <= 1'b1;
                        bus.RRESP  <= r_in_range ? RESP_OKAY : RESP_SLVERR;
                        bus.RDATA  <= r_in_range ? mem[r_idx[IDX_W-1:0]] : '0;
                    end
                end
                R_RESP: begin
                    if (r_hs) begin
                        bus.RVALID  <= 1'b0;
                        bus.ARREADY <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_subordinate_mem.sv
// Bench for axi4_subordinate_mem: directed corner cases plus randomized single-beat traffic
// checked against an associative-array memory model and an expected-read queue.
module tb_axi4_subordinate_mem;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int MEM_DEPTH = 1024;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] w_state_dbg;
    logic       r_state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] model_mem[int];
    logic [ADDR_W-1:0] written_q[$];

    axi4_subordinate_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    axi4_subordinate_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH)) dut (
        .ACLK       (clk),
        .ARESETn    (rst_n),
        .bus        (bus),
        .w_state_dbg(w_state_dbg),
        .r_state_dbg(r_state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit expected normal end");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic bit in_range(input logic [ADDR_W-1:0] a);
        return (a / 4) < 32'(MEM_DEPTH);
    endfunction

    function automatic logic [1:0] exp_resp(input logic [ADDR_W-1:0] a);
        return in_range(a) ? OKAY : SLVERR;
    endfunction

    function automatic void model_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        if (in_range(a)) model_mem[int'(a / 4)] = d;
    endfunction

    function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a);
        if (!in_range(a)) return '0;
        if (model_mem.exists(int'(a / 4))) return model_mem[int'(a / 4)];
        return 'x;
    endfunction

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    // ---------------- drivers ----------------
    task automatic bus_idle();
        bus.AWADDR  = '0; bus.AWVALID = 1'b0;
        bus.WDATA   = '0; bus.WVALID  = 1'b0;
        bus.BREADY  = 1'b0;
        bus.ARADDR  = '0; bus.ARVALID = 1'b0;
        bus.RREADY  = 1'b0;
    endtask

    // Asserts reset asynchronously, checks outputs at once, releases mid-cycle and
    // checks readies stay low until the first edge and rise on it.
    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        check("rst_bvalid", bus.BVALID, 0);
        check("rst_rvalid", bus.RVALID, 0);
        check("rst_awready", bus.AWREADY, 0);
        check("rst_wready", bus.WREADY, 0);
        check("rst_arready", bus.ARREADY, 0);
        check("rst_bresp", bus.BRESP, OKAY);
        check("rst_rresp", bus.RRESP, OKAY);
        check("rst_rdata", bus.RDATA, 0);
        bus_idle();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_awready_pre", bus.AWREADY, 0);
        check("rel_arready_pre", bus.ARREADY, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rel_awready", bus.AWREADY, 1);
        check("rel_wready", bus.WREADY, 1);
        check("rel_arready", bus.ARREADY, 1);
        @(posedge clk); #1;
    endtask

    // Entered and left just after a rising edge.
    task automatic axi_write(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                             input int aw_dly, input int w_dly, input int b_dly);
        int   t = 0;
        bit   aw_done = 0, w_done = 0;
        logic aw_hs, w_hs;
        logic [1:0] resp = exp_resp(addr);
        bus.AWADDR = addr;
        bus.WDATA  = data;
        while (!(aw_done && w_done) && t < 40) begin
            bus.AWVALID = !aw_done && (t >= aw_dly);
            bus.WVALID  = !w_done && (t >= w_dly);
            @(negedge clk);
            if (aw_done) check("awready_held", bus.AWREADY, 0);
            else if (bus.AWVALID) check("awready_idle", bus.AWREADY, 1);
            if (w_done) check("wready_held", bus.WREADY, 0);
            else if (bus.WVALID) check("wready_idle", bus.WREADY, 1);
            check("bvalid_before_hs", bus.BVALID, 0);
            aw_hs = bus.AWVALID && bus.AWREADY;
            w_hs  = bus.WVALID && bus.WREADY;
            @(posedge clk); #1;
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done  = 1;
            t++;
        end
        bus.AWVALID = 1'b0;
        bus.WVALID  = 1'b0;
        check("aw_w_accepted", {aw_done, w_done}, 2'b11);
        if (!(aw_done && w_done)) return;
        @(negedge clk);
        check("bvalid_early", bus.BVALID, 0);
        check("awready_commit", bus.AWREADY, 0);
        check("wready_commit", bus.WREADY, 0);
        @(negedge clk);
        check("bvalid_lat", bus.BVALID, 1);
        check("bresp", bus.BRESP, resp);
        model_write(addr, data);
        for (int i = 0; i < b_dly; i++) begin
            @(negedge clk);
            check("bvalid_hold", bus.BVALID, 1);
            check("bresp_hold", bus.BRESP, resp);
            check("awready_resp", bus.AWREADY, 0);
            check("wready_resp", bus.WREADY, 0);
        end
        bus.BREADY = 1'b1;
        @(posedge clk); #1;
        bus.BREADY = 1'b0;
        @(negedge clk);
        check("bvalid_clear", bus.BVALID, 0);
        check("awready_back", bus.AWREADY, 1);
        check("wready_back", bus.WREADY, 1);
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [ADDR_W-1:0] addr, input int r_dly);
        int   t = 0;
        bit   ar_done = 0;
        logic [DATA_W-1:0] exp_d;
        logic [1:0] resp = exp_resp(addr);
        exp_q.push_back(model_read(addr));
        bus.ARADDR  = addr;
        bus.ARVALID = 1'b1;
        while (!ar_done && t < 20) begin
            @(negedge clk);
            check("arready_idle", bus.ARREADY, 1);
            check("rvalid_pre", bus.RVALID, 0);
            ar_done = bus.ARREADY;
            @(posedge clk); #1;
            t++;
        end
        bus.ARVALID = 1'b0;
        exp_d = exp_q.pop_front();
        if (!ar_done) return;
        @(negedge clk);
        check("rvalid_lat", bus.RVALID, 1);
        check("rdata", bus.RDATA, exp_d);
        check("rresp", bus.RRESP, resp);
        check("arready_busy", bus.ARREADY, 0);
        for (int i = 0; i < r_dly; i++) begin
            @(negedge clk);
            check("rvalid_hold", bus.RVALID, 1);
            check("rdata_hold", bus.RDATA, exp_d);
            check("rresp_hold", bus.RRESP, resp);
            check("arready_hold", bus.ARREADY, 0);
        end
        bus.RREADY = 1'b1;
        @(posedge clk); #1;
        bus.RREADY = 1'b0;
        @(negedge clk);
        check("rvalid_clear", bus.RVALID, 0);
        check("arready_back", bus.ARREADY, 1);
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int sel;

        bus_idle();
        #1;
        pulse_reset();

        // same-cycle AW/W, immediate read-back
        axi_write(32'h10, 32'hDEADBEEF, 0, 0, 0);
        axi_read(32'h10, 0);

        // W leads AW by 5 cycles
        axi_write(32'h20, 32'h12345678, 5, 0, 0);
        axi_read(32'h20, 0);

        // response back-pressure
        axi_write(32'h30, 32'hCAFEF00D, 0, 2, 4);
        axi_read(32'h30, 3);

        // out-of-range must not alias onto word 0
        axi_write(32'h0, 32'h000055AA, 0, 0, 0);
        axi_write(32'h1000, 32'hBAD0BAD0, 0, 0, 1);
        axi_read(32'h1000, 0);
        axi_read(32'h0, 0);

        // read handshaking on the commit edge sees the old word
        axi_write(32'h10, 32'hA, 0, 0, 0);
        bus.AWADDR = 32'h10; bus.WDATA = 32'hB;
        bus.AWVALID = 1'b1;  bus.WVALID = 1'b1;
        @(posedge clk); #1;
        bus.AWVALID = 1'b0;  bus.WVALID = 1'b0;
        bus.ARADDR = 32'h10; bus.ARVALID = 1'b1;
        exp_q.push_back(model_read(32'h10));
        @(negedge clk);
        check("race_arready", bus.ARREADY, 1);
        check("race_bvalid_early", bus.BVALID, 0);
        @(posedge clk); #1;
        bus.ARVALID = 1'b0;
        model_write(32'h10, 32'hB);
        @(negedge clk);
        check("race_rvalid", bus.RVALID, 1);
        check("race_rdata_old", bus.RDATA, exp_q.pop_front());
        check("race_bvalid", bus.BVALID, 1);
        check("race_bresp", bus.BRESP, OKAY);
        bus.BREADY = 1'b1; bus.RREADY = 1'b1;
        @(posedge clk); #1;
        bus.BREADY = 1'b0; bus.RREADY = 1'b0;
        @(negedge clk);
        check("race_bvalid_clear", bus.BVALID, 0);
        check("race_rvalid_clear", bus.RVALID, 0);
        @(posedge clk); #1;
        axi_read(32'h10, 0);

        // reset while both responses are pending; the commit edge already happened
        bus.AWADDR = 32'h40; bus.WDATA = 32'h4040_4040;
        bus.AWVALID = 1'b1;  bus.WVALID = 1'b1;
        @(posedge clk); #1;
        bus.AWVALID = 1'b0;  bus.WVALID = 1'b0;
        @(posedge clk); #1;
        model_write(32'h40, 32'h4040_4040);
        bus.ARADDR = 32'h10; bus.ARVALID = 1'b1;
        @(posedge clk); #1;
        bus.ARVALID = 1'b0;
        @(negedge clk);
        check("pre_rst_bvalid", bus.BVALID, 1);
        check("pre_rst_rvalid", bus.RVALID, 1);
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_spurious_b", bus.BVALID, 0);
            check("no_spurious_r", bus.RVALID, 0);
        end
        @(posedge clk); #1;
        axi_read(32'h40, 0);

        // reset during the commit cycle: memory keeps the old word
        axi_write(32'h44, 32'h1111_2222, 0, 0, 0);
        bus.AWADDR = 32'h44; bus.WDATA = 32'h3333_4444;
        bus.AWVALID = 1'b1;  bus.WVALID = 1'b1;
        @(posedge clk); #1;
        bus.AWVALID = 1'b0;  bus.WVALID = 1'b0;
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("dropped_no_b", bus.BVALID, 0);
        end
        @(posedge clk); #1;
        axi_read(32'h44, 0);

        // randomized traffic
        for (int n = 0; n < 30; n++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      addr = 32'h1000 + 32'($urandom_range(0, 255));
            else if (sel == 1) addr = $urandom | 32'h8000_0000;
            else               addr = 32'($urandom_range(0, 'hFFF));
            data = $urandom;
            axi_write(addr, data, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3));
            if (in_range(addr)) written_q.push_back(addr);
            if (written_q.size() > 0 && $urandom_range(0, 1) == 1)
                axi_read(written_q[$urandom_range(0, written_q.size() - 1)], $urandom_range(0, 3));
            else
                axi_read(addr, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
